mem_interface_queued: RTL and testbench

- Parametrised successor to the single-cycle core memory interface.
- Accepts read and write requests through a valid/ready handshake and buffers them in an in-order request FIFO.
- Executes requests against an internal word RAM and returns read data through a READ_LATENCY-deep pipeline that can be stalled by the consumer.
- Sits between the core's fetch/load-store unit and memory; it is the drop-in path towards cached or multi-cycle memories.

---
 rtl/mem_if_pkg.sv | 24 ++
 rtl/mem_interface_queued_if.sv | 28 ++
 rtl/mem_if_req_fifo.sv | 38 +++
 rtl/mem_interface_queued.sv | 151 +++++++++++++++
 tb/tb_mem_interface_queued.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the queued memory interface.
// Entry/response typedefs describe the default geometry; the top builds
// width-parameterised equivalents with the same field order.
package mem_if_pkg;

  localparam int unsigned STAT_WIDTH       = 32;
  localparam int unsigned DEF_ADDRESS_BITS = 12;
  localparam int unsigned DEF_DATA_WIDTH   = 32;

  typedef struct packed {
    logic                          rd;
    logic                          wr;
    logic [DEF_ADDRESS_BITS-1:0]   raddr;
    logic [DEF_ADDRESS_BITS-1:0]   waddr;
    logic [DEF_DATA_WIDTH-1:0]     data;
    logic [DEF_DATA_WIDTH/8-1:0]   byte_en;
  } req_t;

  typedef struct packed {
    logic [DEF_ADDRESS_BITS-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0]   data;
  } resp_t;

endpackage

// File: rtl/mem_interface_queued_if.sv
// Request/response bus of the queued memory interface.
// master = core side (requester + response consumer), slave = memory side.
interface mem_interface_queued_if #(
  parameter int unsigned ADDRESS_BITS = 12,
  parameter int unsigned DATA_WIDTH   = 32
);
  logic                      read;
  logic                      write;
  logic [ADDRESS_BITS-1:0]   read_address;
  logic [ADDRESS_BITS-1:0]   write_address;
  logic [DATA_WIDTH-1:0]     in_data;
  logic [DATA_WIDTH/8-1:0]   byte_en;
  logic                      ready;
  logic                      resp_ready;
  logic                      valid;
  logic [ADDRESS_BITS-1:0]   out_addr;
  logic [DATA_WIDTH-1:0]     out_data;

  modport master (
    output read, write, read_address, write_address, in_data, byte_en, resp_ready,
    input  ready, valid, out_addr, out_data
  );

  modport slave (
    input  read, write, read_address, write_address, in_data, byte_en, resp_ready,
    output ready, valid, out_addr, out_data
  );
endinterface

// File: rtl/mem_if_req_fifo.sv
// In-order synchronous request FIFO with wrap-bit pointers.
module mem_if_req_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      slots [DEPTH];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = slots[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !reset) slots[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mem_interface_queued.sv
// Queued memory interface: request FIFO -> word RAM -> stallable read pipe.
// Optional MEM_IF_STATS_EN builds the stat counters and the report port.
module mem_interface_queued
  import mem_if_pkg::*;
#(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 12,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef MEM_IF_STATS_EN
  input  logic                   report,
`endif
  mem_interface_queued_if.slave  bus,
  output logic [STAT_WIDTH-1:0]  stat_reads,
  output logic [STAT_WIDTH-1:0]  stat_writes,
  output logic [STAT_WIDTH-1:0]  stat_stalls
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned WORDS = 2 ** ADDRESS_BITS;

  typedef struct packed {
    logic                    rd;
    logic                    wr;
    logic [ADDRESS_BITS-1:0] raddr;
    logic [ADDRESS_BITS-1:0] waddr;
    logic [DATA_WIDTH-1:0]   data;
    logic [BYTES-1:0]        byte_en;
  } entry_t;

  entry_t push_entry;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   accept;
  logic   issue;
  logic   stall;

  assign bus.ready = !fifo_full;
  assign accept    = (bus.read || bus.write) && !fifo_full;
  assign stall     = bus.valid && !bus.resp_ready;
  assign issue     = !fifo_empty && !stall;

  always_comb begin
    push_entry = '{rd: bus.read, wr: bus.write, raddr: bus.read_address,
                   waddr: bus.write_address, data: bus.in_data, byte_en: bus.byte_en};
  end

  mem_if_req_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_req_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (issue),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  logic [DATA_WIDTH-1:0] ram [WORDS];
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clock) begin
    if (issue && head.wr && !reset) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (head.byte_en[b]) ram[head.waddr][8*b +: 8] <= head.data[8*b +: 8];
      end
    end
  end

  // A combined entry writes first: forward its enabled bytes into the read.
  always_comb begin
    rd_word = ram[head.raddr];
    if (head.wr && (head.waddr == head.raddr)) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (head.byte_en[b]) rd_word[8*b +: 8] = head.data[8*b +: 8];
      end
    end
  end

  logic [READ_LATENCY-1:0] pipe_v;
  logic [ADDRESS_BITS-1:0] pipe_a [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_d [READ_LATENCY];
  logic                    issue_rd;

  assign issue_rd = issue && head.rd;

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_a[i] <= '0;
        pipe_d[i] <= '0;
      end
    end else if (!stall) begin
      pipe_v[0] <= issue_rd;
      pipe_a[0] <= issue_rd ? head.raddr : '0;
      pipe_d[0] <= issue_rd ? rd_word : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign bus.valid    = pipe_v[READ_LATENCY-1];
  assign bus.out_addr = pipe_a[READ_LATENCY-1];
  assign bus.out_data = pipe_d[READ_LATENCY-1];

`ifdef MEM_IF_STATS_EN
  logic [STAT_WIDTH-1:0] n_reads;
  logic [STAT_WIDTH-1:0] n_writes;
  logic [STAT_WIDTH-1:0] n_stalls;

  always_ff @(posedge clock) begin
    if (reset) begin
      n_reads  <= '0;
      n_writes <= '0;
      n_stalls <= '0;
    end else begin
      if (accept && bus.read)  n_reads  <= n_reads  + STAT_WIDTH'(1);
      if (accept && bus.write) n_writes <= n_writes + STAT_WIDTH'(1);
      if (stall)               n_stalls <= n_stalls + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (report)
      $display("mem_if core %0d: reads=%0d writes=%0d stalls=%0d",
               CORE, n_reads, n_writes, n_stalls);
  end

  assign stat_reads  = n_reads;
  assign stat_writes = n_writes;
  assign stat_stalls = n_stalls;
`else
  logic unused_core;
  assign unused_core = ^CORE;

  assign stat_reads  = '0;
  assign stat_writes = '0;
  assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_mem_interface_queued.sv
// Directed bench for mem_interface_queued (default geometry, latency 2).
module tb_mem_interface_queued;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] stat_reads;
  logic [31:0] stat_writes;
  logic [31:0] stat_stalls;

`ifdef MEM_IF_STATS_EN
  logic report = 1'b0;
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  mem_interface_queued_if #(.ADDRESS_BITS(12), .DATA_WIDTH(32)) bus ();

  mem_interface_queued #(
    .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(12), .FIFO_DEPTH(4), .READ_LATENCY(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef MEM_IF_STATS_EN
    .report      (report),
`endif
    .bus         (bus),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_stalls (stat_stalls)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned wait_n;
  int unsigned valid_seen;
  int unsigned bad_ready;
  int unsigned bad_resp;
  int unsigned n_resp;

  function automatic logic [31:0] st(input logic [31:0] n);
    return STATS ? n : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic send(input logic rd, input logic wr, input logic [11:0] ra,
                      input logic [11:0] wa, input logic [31:0] d, input logic [3:0] be);
    int unsigned n = 0;
    bus.read = rd; bus.write = wr;
    bus.read_address = ra; bus.write_address = wa;
    bus.in_data = d; bus.byte_en = be;
    while (!bus.ready && n < 50) begin tick(); n++; end
    check("send_ready", bus.ready, 1'b1);
    tick();
    idle();
  endtask

  task automatic expect_resp(input string tag, input logic [11:0] a, input logic [31:0] d);
    int unsigned n = 0;
    while (!bus.valid && n < 50) begin tick(); n++; end
    check({tag, "_valid"}, bus.valid, 1'b1);
    check({tag, "_addr"}, bus.out_addr, a);
    check({tag, "_data"}, bus.out_data, d);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    bus.read_address = '0; bus.write_address = '0;
    bus.in_data = '0; bus.byte_en = '0;
    idle();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid", bus.valid, 1'b0);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_addr", bus.out_addr, 12'h000);
    check("rst_data", bus.out_data, 32'h0);
    check("rst_reads", stat_reads, 32'd0);

    // Write then read: response exactly 3 cycles after acceptance
    send(1'b0, 1'b1, 12'h000, 12'h010, 32'hDEADBEEF, 4'hF);
    bus.read = 1'b1; bus.read_address = 12'h010;
    check("lat_ready", bus.ready, 1'b1);
    tick(); idle();
    check("lat_c1", bus.valid, 1'b0);
    tick();
    check("lat_c2", bus.valid, 1'b0);
    tick();
    check("lat_valid", bus.valid, 1'b1);
    check("lat_addr", bus.out_addr, 12'h010);
    check("lat_data", bus.out_data, 32'hDEADBEEF);
    tick();

    // Byte-masked overwrite
    send(1'b0, 1'b1, 12'h000, 12'h020, 32'h11223344, 4'hF);
    send(1'b0, 1'b1, 12'h000, 12'h020, 32'hAABBCCDD, 4'h5);
    send(1'b1, 1'b0, 12'h020, 12'h000, 32'h0, 4'h0);
    expect_resp("rmw", 12'h020, 32'h11BB33DD);

    // Combined read+write: the read sees the new data
    send(1'b1, 1'b1, 12'h030, 12'h030, 32'h5A5A5A5A, 4'hF);
    expect_resp("comb", 12'h030, 32'h5A5A5A5A);

    send(1'b0, 1'b1, 12'h000, 12'h040, 32'hC0DE0040, 4'hF);
    send(1'b0, 1'b1, 12'h000, 12'h050, 32'hC0DE0050, 4'hF);
    check("pre_reads", stat_reads, st(32'd3));
    check("pre_writes", stat_writes, st(32'd6));
    check("pre_stalls", stat_stalls, st(32'd0));

    // Stall: R0 held at the output while the queue fills
    bus.resp_ready = 1'b0;
    send(1'b1, 1'b0, 12'h010, 12'h000, 32'h0, 4'h0);
    tick(); tick();
    check("stall_r0_valid", bus.valid, 1'b1);
    check("stall_r0_data", bus.out_data, 32'hDEADBEEF);
    check("stall_s0", stat_stalls, st(32'd0));
    for (int unsigned i = 0; i < 4; i++) begin
      bus.read = 1'b1;
      bus.read_address = 12'h020 + 12'(16 * i);
      check("stall_acc_ready", bus.ready, 1'b1);
      tick();
    end
    bus.read_address = 12'h040;
    check("full_ready", bus.ready, 1'b0);
    check("full_s4", stat_stalls, st(32'd4));
    tick(); tick();
    check("full_ready2", bus.ready, 1'b0);
    check("hold_valid", bus.valid, 1'b1);
    check("hold_addr", bus.out_addr, 12'h010);
    check("hold_data", bus.out_data, 32'hDEADBEEF);
    check("hold_s6", stat_stalls, st(32'd6));
    check("hold_reads", stat_reads, st(32'd8));
    bus.resp_ready = 1'b1;
    tick();
    check("drain_gap", bus.valid, 1'b0);
    check("drain_ready", bus.ready, 1'b1);
    tick();
    idle();
    expect_resp("r1", 12'h020, 32'h11BB33DD);
    expect_resp("r2", 12'h030, 32'h5A5A5A5A);
    expect_resp("r3", 12'h040, 32'hC0DE0040);
    expect_resp("r4", 12'h050, 32'hC0DE0050);
    expect_resp("r5", 12'h040, 32'hC0DE0040);
    check("post_reads", stat_reads, st(32'd9));
    check("post_stalls", stat_stalls, st(32'd6));

    // Reset with 2 reads in flight and 3 entries queued (last one a write)
    bus.resp_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      bus.read  = (i < 4);
      bus.write = (i == 4);
      bus.read_address  = 12'h010 + 12'(16 * i);
      bus.write_address = 12'h010;
      bus.in_data = 32'hFFFFFFFF; bus.byte_en = 4'hF;
      check("mid_ready", bus.ready, 1'b1);
      tick();
    end
    idle();
    check("mid_valid", bus.valid, 1'b1);
    check("mid_addr", bus.out_addr, 12'h010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", bus.valid, 1'b0);
    check("mrst_ready", bus.ready, 1'b1);
    check("mrst_addr", bus.out_addr, 12'h000);
    check("mrst_data", bus.out_data, 32'h0);
    check("mrst_reads", stat_reads, 32'd0);
    check("mrst_writes", stat_writes, 32'd0);
    check("mrst_stalls", stat_stalls, 32'd0);
    bus.resp_ready = 1'b1;
    valid_seen = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      if (bus.valid) valid_seen++;
    end
    check("mrst_no_resp", valid_seen, 0);

    // 1000 back-to-back reads
    bad_ready = 0; bad_resp = 0; n_resp = 0;
    for (int unsigned c = 0; c < 1003; c++) begin
      if (c < 1000) begin
        bus.read = 1'b1;
        bus.read_address = c[11:0];
        if (!bus.ready) bad_ready++;
      end else begin
        idle();
      end
      tick();
      if (c >= 2 && c < 1002) begin
        if (bus.valid && bus.out_addr == 12'(c - 2)) n_resp++;
        else bad_resp++;
      end else if (bus.valid) begin
        bad_resp++;
      end
    end
    check("b2b_ready_drops", bad_ready, 0);
    check("b2b_bad_resp", bad_resp, 0);
    check("b2b_n_resp", n_resp, 1000);
    check("b2b_reads", stat_reads, st(32'd1000));

    // The write queued before the reset must not have landed
    send(1'b1, 1'b0, 12'h010, 12'h000, 32'h0, 4'h0);
    expect_resp("no_partial", 12'h010, 32'hDEADBEEF);
    check("final_reads", stat_reads, st(32'd1001));
    check("final_writes", stat_writes, st(32'd0));

    wait_n = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
